// File: rtl/ov7725_sccb_cfg.sv
// OV7725 power-up SCCB configuration sequencer.
// Walks an external {reg_addr, reg_data} table and issues one 3-phase SCCB
// write per entry. An entry whose reg_addr is 8'hFF is a delay marker instead.
module ov7725_sccb_cfg #(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          SCL_FREQ_HZ = 250_000,
    parameter logic [7:0]  DEV_ADDR    = 8'h42,
    parameter int          REG_NUM     = 70,
    parameter int          PWR_DLY     = 1_000_000,
    parameter int          DLY_UNIT    = 50_000,
    localparam int         IW          = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic [IW-1:0] o_reg_idx,
    input  logic [15:0]   i_reg_data,
    output logic          ova_cfg_scl,
    output logic          ova_cfg_sda_o,
    output logic          ova_cfg_sda_oe,
    input  logic          ova_cfg_sda_i,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_ack_err
);

    localparam int QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
    localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PWR_WAIT, S_LOAD, S_DELAY, S_START,
        S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   dly_last_q, dly_last_d;
    logic [15:0]   entry_q, entry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ack_err_q, ack_err_d;
    logic          scl_q, scl_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          bus_st;
    logic          tick;
    logic          qend;
    logic          advance;
    logic [7:0]    byte_sel;
    logic          bit_val;

    // Quarter-bit timebase only runs while the bus is owned, so every
    // transfer starts phase-aligned to the state entry.
    always_comb begin
        bus_st = state_q inside {S_START, S_BYTE, S_ACK, S_STOP, S_GAP};
        tick   = bus_st && (qcnt_q == QW'(QDIV - 1));
        qend   = tick && (qtr_q == 2'd3);
        qcnt_d = (!bus_st || tick) ? '0 : qcnt_q + QW'(1);
    end

    // Next-state logic for the table walk and bit sequencing.
    always_comb begin
        state_d    = state_q;
        qtr_d      = qtr_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        dly_last_d = dly_last_q;
        entry_d    = entry_q;
        idx_d      = idx_q;
        ack_err_d  = ack_err_q;
        advance    = 1'b0;

        if (tick) qtr_d = qtr_q + 2'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d   = S_LOAD;
                    idx_d     = '0;
                    ack_err_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_PWR_WAIT: begin
                if (cnt_q == 32'(PWR_DLY - 1)) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // ROM output settles one cycle after the index moves; latch on the second.
            S_LOAD: begin
                if (cnt_q == 32'd1) begin
                    cnt_d   = '0;
                    entry_d = i_reg_data;
                    if (i_reg_data[15:8] == 8'hFF) begin
                        state_d    = S_DELAY;
                        dly_last_d = (i_reg_data[7:0] == 8'd0) ? 32'd0 :
                                     32'(i_reg_data[7:0]) * 32'(DLY_UNIT) - 32'd1;
                    end else begin
                        state_d = S_START;
                        qtr_d   = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DELAY: begin
                if (cnt_q == dly_last_q) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START: begin
                if (qend) begin
                    state_d = S_BYTE;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                end
            end
            S_BYTE: begin
                if (qend) begin
                    if (bit_q == 3'd7) state_d = S_ACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_ACK: begin
                if (tick && qtr_q == 2'd2 && ova_cfg_sda_i) ack_err_d = 1'b1;
                if (qend) begin
                    bit_d = 3'd0;
                    if (byte_q == 2'd2) begin
                        state_d = S_STOP;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        state_d = S_BYTE;
                    end
                end
            end
            S_STOP: begin
                if (qend) state_d = S_GAP;
            end
            S_GAP: begin
                if (qend) advance = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Index stays on the last entry once the table is exhausted.
        if (advance) begin
            if (32'(idx_q) + 32'd1 == 32'(REG_NUM)) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = S_LOAD;
            end
        end
    end

    // Bus pin decode from the next state so the pins flip on the same edge as the phase.
    always_comb begin
        unique case (byte_d)
            2'd0:    byte_sel = DEV_ADDR;
            2'd1:    byte_sel = entry_d[15:8];
            default: byte_sel = entry_d[7:0];
        endcase
        bit_val = byte_sel[3'd7 - bit_d];

        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_START: oe_d = qtr_d[1];
            S_BYTE: begin
                scl_d = qtr_d[1];
                oe_d  = ~bit_val;
            end
            S_ACK:   scl_d = qtr_d[1];
            S_STOP: begin
                scl_d = qtr_d[1];
                oe_d  = (qtr_d != 2'd3);
            end
            default: ;
        endcase

        busy_d = !(state_d inside {S_IDLE, S_DONE});
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; reset drops the bus immediately without a STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_PWR_WAIT;
            qcnt_q     <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            cnt_q      <= '0;
            dly_last_q <= '0;
            entry_q    <= '0;
            idx_q      <= '0;
            ack_err_q  <= 1'b0;
            scl_q      <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            cnt_q      <= cnt_d;
            dly_last_q <= dly_last_d;
            entry_q    <= entry_d;
            idx_q      <= idx_d;
            ack_err_q  <= ack_err_d;
            scl_q      <= scl_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_reg_idx      = idx_q;
    assign ova_cfg_scl    = scl_q;
    assign ova_cfg_sda_o  = 1'b0;
    assign ova_cfg_sda_oe = oe_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_ack_err      = ack_err_q;

endmodule

// File: tb/tb_ov7725_sccb_cfg.sv
// Bench for ov7725_sccb_cfg: bus monitor decodes START/bits/STOP and checks
// each frame against a scoreboard of expected table writes.
module tb_ov7725_sccb_cfg;

    localparam int         CLK_HZ   = 1_600_000;
    localparam int         SCL_HZ   = 100_000;
    localparam int         QDIV     = CLK_HZ / (4 * SCL_HZ);
    localparam int         REG_NUM  = 4;
    localparam int         PWR_DLY  = 200;
    localparam int         DLY_UNIT = 50;
    localparam int         IW       = 2;
    localparam logic [7:0] DEV      = 8'h42;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [IW-1:0] o_reg_idx;
    logic [15:0]   i_reg_data;
    logic          scl, sda_o, sda_oe, sda_i, busy, done, ack_err;

    typedef struct { logic [7:0] a; logic [7:0] d; int idx; } exp_t;
    exp_t        sb[$];
    logic [15:0] tbl [REG_NUM];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        scl_p = 1'b1, sda_p = 1'b1, ln = 1'b1, in_frame = 1'b0;
    int          bitcnt = 0, start_cnt = 0, stop_cnt = 0, scl_edges = 0;
    int          last_start = 0, last_stop = 0, last_rise = 0, period = 0;
    logic [26:0] bits = '0;
    logic        nak_en = 1'b0;
    int          nak_start = 0;
    logic        busy_prev = 1'b0;
    int          walk_base = 0, stop_base = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) i_reg_data <= tbl[o_reg_idx];

    assign sda_i = nak_en && in_frame && (start_cnt == nak_start) && (bitcnt == 18);

    ov7725_sccb_cfg #(
        .CLK_FREQ_HZ(CLK_HZ), .SCL_FREQ_HZ(SCL_HZ), .DEV_ADDR(DEV),
        .REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY), .DLY_UNIT(DLY_UNIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .o_reg_idx(o_reg_idx), .i_reg_data(i_reg_data),
        .ova_cfg_scl(scl), .ova_cfg_sda_o(sda_o), .ova_cfg_sda_oe(sda_oe),
        .ova_cfg_sda_i(sda_i), .o_busy(busy), .o_done(done), .o_ack_err(ack_err)
    );

    task automatic set_tbl(input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic [15:0] t3);
        tbl[0] = t0; tbl[1] = t1; tbl[2] = t2; tbl[3] = t3;
    endtask

    task automatic push_walk();
        exp_t e;
        for (int i = 0; i < REG_NUM; i++) begin
            if (tbl[i][15:8] != 8'hFF) begin
                e.a = tbl[i][15:8]; e.d = tbl[i][7:0]; e.idx = i;
                sb.push_back(e);
            end
        end
    endtask

    // Advance to the next falling clock edge and decode the bus.
    task automatic step();
        exp_t        e;
        logic [26:0] x;
        @(negedge clk);
        ln = sda_oe ? sda_o : 1'b1;
        if (!rst_n) begin
            in_frame = 1'b0; bitcnt = 0; scl_p = 1'b1; sda_p = 1'b1;
            return;
        end
        if (scl_p != scl) scl_edges++;
        if (scl_p && scl && sda_p && !ln) begin
            start_cnt++; last_start = cyc; in_frame = 1'b1; bitcnt = 0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected: START at idx %0d, no transfer expected", o_reg_idx);
            end else if (o_reg_idx !== IW'(sb[0].idx)) begin
                errors++;
                $display("FAIL start_idx: got idx %0d expected %0d", o_reg_idx, sb[0].idx);
            end
        end else if (scl_p && scl && !sda_p && ln) begin
            stop_cnt++; last_stop = cyc;
            if (in_frame) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stop_unexpected: frame %h with nothing expected", bits);
                end else begin
                    e = sb.pop_front();
                    x = {DEV, 1'b1, e.a, 1'b1, e.d, 1'b1};
                    if (bitcnt != 27 || bits !== x) begin
                        errors++;
                        $display("FAIL frame_%0d: got %0d bits %h expected 27 bits %h", e.idx, bitcnt, bits, x);
                    end
                end
            end
            in_frame = 1'b0;
        end else if (!scl_p && scl && in_frame && bitcnt < 27) begin
            bits[26 - bitcnt] = ln;
            bitcnt++;
            if (bitcnt > 1) period = cyc - last_rise;
            last_rise = cyc;
        end
        scl_p = scl; sda_p = ln;
    endtask

    task automatic wait_starts(input int n, input string nm);
        int b = 0;
        while (start_cnt < n && b < 20000) begin step(); b++; end
        if (start_cnt < n) begin
            checks++; errors++;
            $display("FAIL %s: timeout, got %0d STARTs expected %0d", nm, start_cnt, n);
        end
    endtask

    task automatic wait_stops(input int n, input string nm);
        int b = 0;
        while (stop_cnt < n && b < 20000) begin step(); b++; end
        if (stop_cnt < n) begin
            checks++; errors++;
            $display("FAIL %s: timeout, got %0d STOPs expected %0d", nm, stop_cnt, n);
        end
    endtask

    task automatic wait_done(input string nm);
        int b = 0;
        while (done !== 1'b1 && b < 20000) begin busy_prev = busy; step(); b++; end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s: timeout waiting for o_done, got %b expected 1", nm, done);
        end else if ({busy_prev, busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s_busy_fall: busy prev/now got %b%b expected 10", nm, busy_prev, busy);
        end
    endtask

    task automatic wait_pwr(input int t0, input string nm);
        int b = 0;
        int eb;
        eb = scl_edges;
        while (scl_edges == eb && b < 20000) begin step(); b++; end
        checks++;
        if (scl_edges == eb) begin
            errors++;
            $display("FAIL %s: no scl edge within budget, got 0 expected 1", nm);
        end else if (cyc - t0 < PWR_DLY) begin
            errors++;
            $display("FAIL %s: first scl edge after %0d clk, required >= %0d", nm, cyc - t0, PWR_DLY);
        end
    endtask

    task automatic test_reset();
        set_tbl(16'h1280, 16'hFF02, 16'h3456, 16'h789A);
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({scl, sda_oe, sda_o} !== 3'b100) begin
            errors++; $display("FAIL reset_bus: scl/oe/o got %b%b%b expected 100", scl, sda_oe, sda_o);
        end
        checks++;
        if (o_reg_idx !== '0) begin
            errors++; $display("FAIL reset_idx: got %0d expected 0", o_reg_idx);
        end
        checks++;
        if ({busy, done, ack_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: busy/done/err got %b%b%b expected 000", busy, done, ack_err);
        end
        push_walk();
    endtask

    task automatic test_powerup();
        int t0;
        int d;
        walk_base = start_cnt; stop_base = stop_cnt;
        rst_n = 1'b1; t0 = cyc;
        repeat (4) step();
        checks++;
        if ({busy, scl, sda_oe} !== 3'b110) begin
            errors++; $display("FAIL pwr_wait_state: busy/scl/oe got %b%b%b expected 110", busy, scl, sda_oe);
        end
        wait_pwr(t0, "pwr_delay");
        wait_stops(stop_base + 1, "first_stop");
        checks++;
        if (period != 4 * QDIV) begin
            errors++; $display("FAIL scl_period: got %0d clk expected %0d", period, 4 * QDIV);
        end
        wait_starts(walk_base + 2, "after_delay_start");
        d = last_start - last_stop;
        checks++;
        if (d < 2 * DLY_UNIT + 7 * QDIV || d > 2 * DLY_UNIT + 7 * QDIV + 8) begin
            errors++;
            $display("FAIL delay_marker: STOP->START %0d clk expected %0d..%0d", d,
                     2 * DLY_UNIT + 7 * QDIV, 2 * DLY_UNIT + 7 * QDIV + 8);
        end
        wait_done("walk1_done");
        checks++;
        if (start_cnt - walk_base != 3 || stop_cnt - stop_base != 3) begin
            errors++; $display("FAIL walk1_count: starts/stops got %0d/%0d expected 3/3",
                               start_cnt - walk_base, stop_cnt - stop_base);
        end
        checks++;
        if (sb.size() != 0 || ack_err !== 1'b0 || o_reg_idx !== IW'(REG_NUM - 1)) begin
            errors++; $display("FAIL walk1_end: pending/err/idx got %0d/%b/%0d expected 0/0/%0d",
                               sb.size(), ack_err, o_reg_idx, REG_NUM - 1);
        end
    endtask

    task automatic test_ack_err();
        set_tbl(16'h1280, 16'hA55A, 16'h0F01, 16'hFE7F);
        push_walk();
        walk_base = start_cnt; stop_base = stop_cnt;
        nak_en = 1'b1; nak_start = walk_base + 2;
        i_start = 1'b1; step(); i_start = 1'b0;
        wait_stops(stop_base + 1, "nak_entry0");
        checks++;
        if (ack_err !== 1'b0) begin
            errors++; $display("FAIL ack_err_clean: got %b expected 0", ack_err);
        end
        wait_stops(stop_base + 2, "nak_entry1");
        checks++;
        if (ack_err !== 1'b1) begin
            errors++; $display("FAIL ack_err_set: got %b expected 1", ack_err);
        end
    endtask

    task automatic test_busy_start();
        logic [IW-1:0] idx0;
        idx0 = o_reg_idx;
        i_start = 1'b1; step(); i_start = 1'b0; step();
        checks++;
        if (o_reg_idx !== idx0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL start_while_busy: idx/busy/done got %0d/%b/%b expected %0d/1/0",
                               o_reg_idx, busy, done, idx0);
        end
        wait_done("walk2_done");
        nak_en = 1'b0;
        checks++;
        if (start_cnt - walk_base != 4 || stop_cnt - stop_base != 4) begin
            errors++; $display("FAIL walk2_count: starts/stops got %0d/%0d expected 4/4",
                               start_cnt - walk_base, stop_cnt - stop_base);
        end
        checks++;
        if (ack_err !== 1'b1 || sb.size() != 0) begin
            errors++; $display("FAIL ack_err_sticky: err/pending got %b/%0d expected 1/0", ack_err, sb.size());
        end
    endtask

    task automatic test_restart();
        int c0;
        int lat;
        set_tbl(16'hC33C, 16'h0180, 16'hFF00, 16'h7FFE);
        push_walk();
        walk_base = start_cnt; stop_base = stop_cnt;
        c0 = cyc;
        i_start = 1'b1; step(); i_start = 1'b0;
        checks++;
        if ({done, ack_err, busy} !== 3'b001 || o_reg_idx !== '0) begin
            errors++; $display("FAIL restart_clear: done/err/busy got %b%b%b idx %0d expected 001 idx 0",
                               done, ack_err, busy, o_reg_idx);
        end
        wait_starts(walk_base + 1, "restart_start");
        lat = last_start - c0;
        checks++;
        if (lat < 2 * QDIV || lat > 3 + 2 * QDIV) begin
            errors++; $display("FAIL restart_latency: got %0d clk expected %0d..%0d", lat, 2 * QDIV, 3 + 2 * QDIV);
        end
    endtask

    task automatic test_reset_mid_byte();
        int b = 0;
        int t0;
        while (!(in_frame && bitcnt == 11) && b < 5000) begin step(); b++; end
        checks++;
        if (!(in_frame && bitcnt == 11)) begin
            errors++; $display("FAIL mid_byte_reach: bitcnt got %0d expected 11", bitcnt);
        end
        repeat (2 * QDIV) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scl, sda_oe} !== 2'b10) begin
            errors++; $display("FAIL mid_reset_bus: scl/oe got %b%b expected 10", scl, sda_oe);
        end
        checks++;
        if ({busy, done, ack_err} !== 3'b000 || o_reg_idx !== '0) begin
            errors++; $display("FAIL mid_reset_flags: busy/done/err got %b%b%b idx %0d expected 000 idx 0",
                               busy, done, ack_err, o_reg_idx);
        end
        sb.delete();
        push_walk();
        step(); step();
        walk_base = start_cnt; stop_base = stop_cnt;
        rst_n = 1'b1; t0 = cyc;
        wait_pwr(t0, "mid_reset_pwr");
        wait_done("walk3_done");
        checks++;
        if (start_cnt - walk_base != 3 || stop_cnt - stop_base != 3 || sb.size() != 0) begin
            errors++; $display("FAIL walk3_count: starts/stops/pending got %0d/%0d/%0d expected 3/3/0",
                               start_cnt - walk_base, stop_cnt - stop_base, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_ack_err();
        test_busy_start();
        test_restart();
        test_reset_mid_byte();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ov7725_sccb_cfg.md
Name: ov7725_sccb_cfg

Overview:
Power-up configuration sequencer for the OV7725 camera. It drives SCCB (I2C-compatible, write-only) on ova_cfg_scl/ova_cfg_sda inside cnn_top. It walks an external register table of {reg_addr, reg_data} entries and issues one 3-phase write per entry. After the last entry it asserts o_done, which gates the capture path (i_pclk/href/vsync domain).

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
SCL_FREQ_HZ, 250_000, SCCB bit rate; QDIV = CLK_FREQ_HZ/(4*SCL_FREQ_HZ) clk cycles per quarter-bit (50 at defaults)
DEV_ADDR, 8'h42, camera write address (R/W bit = 0 included)
REG_NUM, 70, number of table entries
PWR_DLY, 1_000_000, clk cycles to wait after reset before the first access (20 ms at defaults)
DLY_UNIT, 50_000, clk cycles per delay-marker count (1 ms at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; restarts the table walk from index 0 when idle/done
o_reg_idx  out  $clog2(REG_NUM)  table index presented to the external ROM
i_reg_data  in  16  {reg_addr[15:8], reg_data[7:0]}; combinational for o_reg_idx, valid one cycle after o_reg_idx changes
ova_cfg_scl  out  1  SCCB clock, push-pull
ova_cfg_sda_o  out  1  SDA drive value (only 0 is used)
ova_cfg_sda_oe  out  1  1 = drive ova_cfg_sda_o; 0 = release (line pulled high)
ova_cfg_sda_i  in  1  SDA line sense, used in ACK slots
o_busy  out  1  high from leaving IDLE until DONE
o_done  out  1  high after all REG_NUM entries are processed; cleared by i_start
o_ack_err  out  1  sticky; set if any ACK slot samples 1; cleared by i_start or reset

Behaviour:
- Reset values: scl=1, sda_oe=0, sda_o=0, o_reg_idx=0, o_busy=0, o_done=0, o_ack_err=0. The FSM enters PWR_WAIT directly; no i_start is needed for the power-up pass.
- Reset mid-transfer: all outputs return to reset values asynchronously. No STOP is issued; the sensor recovers on the next START.
- Quarter tick: a counter 0..QDIV-1 produces a tick on the terminal count. All bus transitions happen on ticks only. Each bit spans 4 quarters: q0 scl=0 with SDA updated; q1 scl=0; q2 scl=1; q3 scl=1.
- FSM states: IDLE -> PWR_WAIT -> LOAD -> (DELAY | START) -> BYTE/ACK x3 -> STOP -> GAP -> LOAD ... -> DONE.
- PWR_WAIT: counts PWR_DLY clk cycles, then goes to LOAD.
- LOAD: waits 2 clk cycles for ROM data, then latches i_reg_data.
  - If reg_addr == 8'hFF, the entry is a delay marker: go to DELAY and wait reg_data*DLY_UNIT cycles. reg_data=0 means zero wait. No bus activity.
  - Otherwise go to START.
- START (4 quarters): sda released for q0–q1, driven low for q2–q3, scl=1 throughout.
- BYTE: shifts MSB first. Byte order is DEV_ADDR, reg_addr, reg_data. Bit '1' = release (oe=0); bit '0' = drive low (oe=1, o=0).
- ACK: 9th bit with SDA released. ova_cfg_sda_i is sampled at the q2->q3 tick; a 1 sets o_ack_err. The transfer always continues; there is no retry.
- STOP (4 quarters): scl=0 with SDA driven low for q0–q1; scl=1 at q2; SDA released at q3.
- GAP: 4 quarters idle (scl=1, sda released).
- After GAP or DELAY, o_reg_idx increments. When the incremented index equals REG_NUM, go to DONE; otherwise go to LOAD. o_reg_idx holds REG_NUM-1 in DONE.
- Per-write bus time: 4 + 27*4 + 4 + 4 = 120 quarters (6000 clk at defaults).
- DONE: o_done=1, o_busy=0, scl=1, sda released.
- i_start in DONE or IDLE: clears o_done and o_ack_err, sets o_reg_idx=0, goes to LOAD. PWR_WAIT is skipped.
- i_start while o_busy=1 is ignored.
- i_start in the same cycle that DONE is entered is ignored. i_start is honoured only while the FSM is already in DONE or IDLE.

Test Plan:
1. Power-up: release reset, defaults, table[0]={12,80}. No scl edge occurs before 1_000_000 clk. The first START is SDA falling while scl=1. The bits observed are 0x42, ACK, 0x12, ACK, 0x80, ACK, then STOP. The scl period is 200 clk.
2. Full table, REG_NUM=4, ack forced 0: exactly 4 STARTs and 4 STOPs occur. o_done rises after the 4th GAP. o_busy falls in the same cycle. o_ack_err=0.
3. ACK error: ova_cfg_sda_i=1 only during the 2nd ACK slot of entry 1 -> o_ack_err=1 and stays set. Entry 1 still completes its 3rd byte and STOP. The remaining entries proceed normally.
4. Delay marker: table[1]={FF,02} -> no bus edges for 100_000 clk after entry 0's GAP. Then o_reg_idx=2 and the next START follows.
5. Reset mid-byte: assert rst_n=0 during bit 5 of reg_addr -> scl=1 and sda_oe=0 immediately. After release, PWR_WAIT runs again and the walk restarts at index 0.
6. Restart: i_start while busy has no effect. i_start in DONE -> o_done=0, o_ack_err=0, and the first START appears within 3 clk + 2 quarters, with no PWR_DLY wait.
